// File: rtl/switch_stats_monitor.sv
// switch_stats_monitor: per-port accept/drop/deliver statistics, in-flight tracking and drain checker
module switch_stats_monitor #(
  parameter int NUM_PORTS  = 4,
  parameter int CNT_W      = 16,
  parameter int DRAIN_TO_W = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                valid_in,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]      target_in,
  input  logic [NUM_PORTS-1:0]                fifo_full,
  input  logic [NUM_PORTS-1:0]                valid_out,
  input  logic                                clear,
  input  logic                                snap_req,
  output logic                                snap_done,
  input  logic [$clog2(NUM_PORTS)-1:0]        rd_port,
  input  logic [1:0]                          rd_sel,
  output logic [CNT_W-1:0]                    rd_data,
  input  logic                                drain_req,
  input  logic [DRAIN_TO_W-1:0]               drain_to,
  output logic                                drain_busy,
  output logic                                drain_ok,
  output logic                                drain_fail,
  output logic [CNT_W+$clog2(NUM_PORTS):0]    inflight,
  output logic [NUM_PORTS-1:0]                sat_flag,
  output logic                                underflow
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int IW = CNT_W + PW + 1;
  localparam int WW = $clog2(NUM_PORTS + 1);
  localparam int SW = $clog2(NUM_PORTS * NUM_PORTS + 1);
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt    [NUM_PORTS][3];
  logic [CNT_W-1:0] cnt_n  [NUM_PORTS][3];
  logic [CNT_W-1:0] shadow [NUM_PORTS][3];
  logic [2:0] ovf [NUM_PORTS];
  logic [WW-1:0] w [NUM_PORTS];
  logic [WW-1:0] inc_a [NUM_PORTS];
  logic [WW-1:0] inc_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] sat_n;
  logic [SW-1:0] acc_sum, dlv_sum;
  logic [IW:0] inf_add;
  logic [IW-1:0] inf_n;
  logic uf;
  logic [CNT_W-1:0] rd_mux;
  logic [DRAIN_TO_W-1:0] timer, timer_dec;
  function automatic logic [WW-1:0] popcnt(input logic [NUM_PORTS-1:0] m);
    logic [WW-1:0] c;
    c = '0;
    for (int j = 0; j < NUM_PORTS; j++) c = c + WW'(m[j]);
    return c;
  endfunction
  // MSB of the result flags an attempted overflow; the value is clamped to all-ones
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] c, input logic [WW-1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? {1'b1, {CNT_W{1'b1}}} : s;
  endfunction
  always_comb begin
    acc_sum = '0;
    dlv_sum = '0;
    sat_n = sat_flag;
    cnt_n = cnt;
    ovf = '{default: '0};
    w = '{default: '0};
    inc_a = '{default: '0};
    inc_d = '{default: '0};
    for (int i = 0; i < NUM_PORTS; i++) begin
      w[i] = popcnt(target_in[i*NUM_PORTS +: NUM_PORTS]);
      inc_a[i] = (valid_in[i] && !fifo_full[i]) ? w[i] : '0;
      inc_d[i] = (valid_in[i] && fifo_full[i]) ? w[i] : '0;
      {ovf[i][0], cnt_n[i][0]} = sat_add(cnt[i][0], inc_a[i]);
      {ovf[i][1], cnt_n[i][1]} = sat_add(cnt[i][1], inc_d[i]);
      {ovf[i][2], cnt_n[i][2]} = sat_add(cnt[i][2], WW'(valid_out[i]));
      sat_n[i] = sat_flag[i] | (|ovf[i]);
      acc_sum = acc_sum + SW'(inc_a[i]);
      dlv_sum = dlv_sum + SW'(valid_out[i]);
    end
    inf_add = {1'b0, inflight} + (IW+1)'(acc_sum);
    uf = inf_add < (IW+1)'(dlv_sum);
    inf_n = uf ? '0 : IW'(inf_add - (IW+1)'(dlv_sum));
    timer_dec = timer - DRAIN_TO_W'(1);
  end
  // unmatched ports and select 3 fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      rd_mux = (rd_port == PW'(i) && rd_sel != 2'd3) ? shadow[i][rd_sel] : rd_mux;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '{default: '0};
      shadow     <= '{default: '0};
      inflight   <= '0;
      sat_flag   <= '0;
      underflow  <= 1'b0;
      drain_busy <= 1'b0;
      drain_ok   <= 1'b0;
      drain_fail <= 1'b0;
      timer      <= '0;
      snap_done  <= 1'b0;
      rd_data    <= '0;
    end else begin
      snap_done <= snap_req;
      rd_data   <= rd_mux;
      if (snap_req) shadow <= cnt;
      if (clear) begin
        cnt        <= '{default: '0};
        inflight   <= '0;
        sat_flag   <= '0;
        underflow  <= 1'b0;
        drain_ok   <= 1'b0;
        drain_fail <= 1'b0;
        drain_busy <= 1'b0;
        state      <= IDLE;
      end else begin
        cnt       <= cnt_n;
        inflight  <= inf_n;
        sat_flag  <= sat_n;
        underflow <= underflow | uf;
        case (state)
          IDLE:
            if (drain_req) begin
              state      <= DRAIN;
              timer      <= drain_to;
              drain_ok   <= 1'b0;
              drain_fail <= 1'b0;
              drain_busy <= 1'b1;
            end
          DRAIN:
            if (inflight == '0) begin
              state    <= DONE;
              drain_ok <= 1'b1;
            end else if (timer_dec == '0) begin
              state      <= DONE;
              drain_fail <= 1'b1;
            end else
              timer <= timer_dec;
          DONE: begin
            state      <= IDLE;
            drain_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_switch_stats_monitor.sv
// tb_switch_stats_monitor: reference-model scoreboard for switch_stats_monitor with narrow counters
module tb_switch_stats_monitor;
  localparam int N = 4;
  localparam int CW = 4;
  localparam int MAXV = 15;
  localparam int IMOD = 128;
  logic clk = 0;
  logic rst_n = 0;
  logic [N-1:0] valid_in = '0, fifo_full = '0, valid_out = '0, sat_flag;
  logic [N*N-1:0] target_in = '0;
  logic clear = 0, snap_req = 0, drain_req = 0;
  logic [1:0] rd_port = '0, rd_sel = '0;
  logic [15:0] drain_to = 16'd1;
  logic snap_done, drain_busy, drain_ok, drain_fail, underflow;
  logic [CW-1:0] rd_data;
  logic [6:0] inflight;
  typedef struct {
    int snap_done; int rd_data; int busy; int ok; int fail; int inflight; int sat; int uf;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int live[N][3], sh[N][3];
  int inf, k, dto;
  bit [N-1:0] m_sat;
  bit m_uf, m_ok, m_fail, dr_on, dn;
  switch_stats_monitor #(.NUM_PORTS(N), .CNT_W(CW), .DRAIN_TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .target_in(target_in),
    .fifo_full(fifo_full), .valid_out(valid_out), .clear(clear), .snap_req(snap_req),
    .snap_done(snap_done), .rd_port(rd_port), .rd_sel(rd_sel), .rd_data(rd_data),
    .drain_req(drain_req), .drain_to(drain_to), .drain_busy(drain_busy),
    .drain_ok(drain_ok), .drain_fail(drain_fail), .inflight(inflight),
    .sat_flag(sat_flag), .underflow(underflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin : model
    int w, v, t, asum, dsum, inf_pre, rd_v;
    int inc[3];
    exp_t e;
    rd_v = (rd_sel < 2'd3) ? sh[rd_port][rd_sel] : 0;
    if (!rst_n) begin
      live = '{default: 0};
      sh = '{default: 0};
      inf = 0; m_sat = '0; m_uf = 0; m_ok = 0; m_fail = 0; dr_on = 0; dn = 0;
      e = '{0, 0, 0, 0, 0, 0, 0, 0};
    end else begin
      if (snap_req) sh = live;
      if (clear) begin
        live = '{default: 0};
        inf = 0; m_sat = '0; m_uf = 0; m_ok = 0; m_fail = 0; dr_on = 0; dn = 0;
      end else begin
        inf_pre = inf; asum = 0; dsum = 0;
        for (int i = 0; i < N; i++) begin
          w = $countones(target_in[i*N +: N]);
          inc[0] = (valid_in[i] && !fifo_full[i]) ? w : 0;
          inc[1] = (valid_in[i] && fifo_full[i]) ? w : 0;
          inc[2] = valid_out[i] ? 1 : 0;
          for (int c = 0; c < 3; c++) begin
            v = live[i][c] + inc[c];
            if (v > MAXV) begin v = MAXV; m_sat[i] = 1; end
            live[i][c] = v;
          end
          asum += inc[0];
          dsum += inc[2];
        end
        t = inf + asum - dsum;
        if (t < 0) begin t = 0; m_uf = 1; end
        inf = t % IMOD;
        if (dn) dn = 0;
        else if (dr_on) begin
          k++;
          if (inf_pre == 0) begin m_ok = 1; dr_on = 0; dn = 1; end
          else if (k == dto) begin m_fail = 1; dr_on = 0; dn = 1; end
        end else if (drain_req) begin
          dr_on = 1; k = 0; dto = int'(drain_to); m_ok = 0; m_fail = 0;
        end
      end
      e = '{int'(snap_req), rd_v, int'(dr_on | dn), int'(m_ok), int'(m_fail), inf, int'(m_sat), int'(m_uf)};
    end
    q.push_back(e);
  end
  task automatic chk(input string n, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, want);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("snap_done", int'(snap_done), e.snap_done);
      chk("rd_data", int'(rd_data), e.rd_data);
      chk("drain_busy", int'(drain_busy), e.busy);
      chk("drain_ok", int'(drain_ok), e.ok);
      chk("drain_fail", int'(drain_fail), e.fail);
      chk("inflight", int'(inflight), e.inflight);
      chk("sat_flag", int'(sat_flag), e.sat);
      chk("underflow", int'(underflow), e.uf);
    end
  end
  task automatic cyc();
    @(negedge clk);
    valid_in = '0; target_in = '0; fifo_full = '0; valid_out = '0;
    clear = 0; snap_req = 0; drain_req = 0;
  endtask
  task automatic send(input int p, input logic [N-1:0] tgt, input logic full);
    valid_in[p] = 1'b1;
    target_in[p*N +: N] = tgt;
    fifo_full[p] = full;
  endtask
  task automatic rd(input int p, input int s);
    rd_port = 2'(p);
    rd_sel = 2'(s);
    cyc();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) begin send(0, 4'b0110, 0); cyc(); end
    snap_req = 1; cyc();
    rd(0, 0); rd(0, 1); rd(0, 2); cyc();
    repeat (2) begin send(2, 4'b1111, 1); cyc(); end
    snap_req = 1; cyc();
    rd(2, 1); rd(2, 0); cyc();
    valid_out = 4'b1111; cyc();
    valid_out = 4'b0011; cyc();
    clear = 1; cyc();
    repeat (20) begin send(1, 4'b0010, 0); cyc(); end
    snap_req = 1; cyc();
    rd(1, 0); rd(1, 3); cyc();
    repeat (5) begin valid_out = '1; cyc(); end
    clear = 1; cyc();
    send(0, 4'b0111, 0); send(3, 4'b0111, 0); cyc();
    valid_out = 4'b1111; cyc();
    valid_out = 4'b0101; cyc();
    drain_req = 1; drain_to = 16'd10; cyc();
    repeat (4) cyc();
    send(1, 4'b1111, 0); send(2, 4'b0001, 0); cyc();
    valid_out = 4'b0111; cyc();
    drain_req = 1; drain_to = 16'd8; cyc();
    drain_req = 1; drain_to = 16'd2; cyc();
    repeat (12) cyc();
    send(0, 4'b0001, 0); cyc();
    snap_req = 1; clear = 1; cyc();
    rd(0, 0); cyc(); cyc();
    valid_out = 4'b1000; cyc(); cyc();
    send(0, 4'b1111, 0); cyc();
    drain_req = 1; drain_to = 16'd50; cyc();
    repeat (3) cyc();
    clear = 1; cyc(); cyc();
    send(0, 4'b1111, 0); cyc();
    drain_req = 1; drain_to = 16'd50; cyc(); cyc();
    rst_n = 0; cyc();
    rst_n = 1; cyc();
    repeat (400) begin
      valid_in = 4'($urandom);
      target_in = 16'($urandom);
      fifo_full = 4'($urandom) & 4'($urandom);
      valid_out = ~(4'($urandom) & 4'($urandom));
      snap_req = ($urandom_range(7) == 0);
      clear = ($urandom_range(63) == 0);
      drain_req = ($urandom_range(15) == 0);
      drain_to = 16'($urandom_range(20, 1));
      rd_port = 2'($urandom);
      rd_sel = 2'($urandom);
      cyc();
    end
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
